// File: rtl/ghost_mode_pkg.sv
// Shared definitions for the ghost mode scheduler: phase states and the
// scatter/chase duration table.
package ghost_mode_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCATTER = 2'd1,
        CHASE   = 2'd2
    } phaseState_e;

    localparam int PHASE_COUNT = 8;
    localparam int PHASE_W     = 11;
    localparam logic [2:0] LAST_PHASE = 3'(PHASE_COUNT - 1);

    // A duration of 0 marks the open-ended final chase phase.
    function automatic logic [PHASE_W-1:0] phaseDuration(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd2:       return 11'd420;
            3'd1, 3'd3, 3'd5: return 11'd1200;
            3'd4, 3'd6:       return 11'd300;
            default:          return 11'd0;
        endcase
    endfunction

endpackage

// File: rtl/ghost_mode_sched_frame_timer.sv
// Loadable frame down-counter with enable (hold when low) and a terminal-count
// flag raised while the count sits at 1.
module frame_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (en) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == W'(1));

endmodule

// File: rtl/ghost_mode_sched.sv
// Ghost scatter/chase phase scheduler with a frightened overlay that freezes the
// phase timer. Frightened support is built only with GHOST_MODE_FRIGHT_EN.
//
// state   | meaning
// IDLE    | no game running, all mode outputs low
// SCATTER | even phase, ghosts head for their corners
// CHASE   | odd phase, ghosts chase; phase 7 never expires
module ghost_mode_sched
    import ghost_mode_pkg::*;
#(
    parameter int FRIGHT_FRAMES = 360,
    parameter int WARN_FRAMES   = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       game_start,
    input  logic       pause,
    input  logic       power_pellet,
    output logic       isScatter,
    output logic       isChase,
    output logic       isFrightened,
    output logic       fright_warn,
    output logic       reverse,
    output logic [2:0] phase_idx
);

    phaseState_e state;
    logic active, tickEn, pelletAccept, frightened, frightExpire;
    logic phaseEn, phaseExpire, phaseLoad, phaseTc;
    logic [PHASE_W-1:0] phaseCount, phaseLoadVal;

    assign active = (state != IDLE);
    assign tickEn = frame_tick & ~pause;

`ifdef GHOST_MODE_FRIGHT_EN
    localparam int FW = $clog2(FRIGHT_FRAMES + 1);

    logic [FW-1:0] frightCount;
    logic frightTc, frightEn, warnNext;

    assign frightened   = isFrightened;
    assign pelletAccept = power_pellet & active & ~game_start;
    assign frightEn     = tickEn & frightened;
    assign frightExpire = frightEn & frightTc & ~pelletAccept & ~game_start;

    frame_timer #(.W(FW)) frightTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (game_start | pelletAccept),
        .loadVal (game_start ? FW'(0) : FW'(FRIGHT_FRAMES)),
        .en      (frightEn),
        .count   (frightCount),
        .tc      (frightTc)
    );

    // Warn must rise on the same edge the count drops into the warn window.
    always_comb begin
        warnNext = 1'b0;
        if (pelletAccept) begin
            warnNext = (FRIGHT_FRAMES <= WARN_FRAMES);
        end else if (frightened && !frightExpire) begin
            warnNext = (frightCount <= FW'(WARN_FRAMES)) ||
                       (frightEn && frightCount == FW'(WARN_FRAMES + 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isFrightened <= 1'b0;
            fright_warn  <= 1'b0;
        end else if (game_start) begin
            isFrightened <= 1'b0;
            fright_warn  <= 1'b0;
        end else begin
            if (pelletAccept) begin
                isFrightened <= 1'b1;
            end else if (frightExpire) begin
                isFrightened <= 1'b0;
            end
            fright_warn <= warnNext;
        end
    end
`else
    logic unusedPellet;

    assign unusedPellet = power_pellet;
    assign frightened   = 1'b0;
    assign pelletAccept = 1'b0;
    assign frightExpire = 1'b0;
    assign isFrightened = 1'b0;
    assign fright_warn  = 1'b0;
`endif

    // A pellet in the same cycle as expiry wins, so the phase count stays at 1.
    assign phaseEn      = active & tickEn & ~frightened & ~pelletAccept & (phaseCount != '0);
    assign phaseExpire  = phaseEn & phaseTc & ~game_start & (phase_idx != LAST_PHASE);
    assign phaseLoad    = game_start | phaseExpire;
    assign phaseLoadVal = game_start ? phaseDuration(3'd0) : phaseDuration(phase_idx + 3'd1);

    frame_timer #(.W(PHASE_W)) phaseTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (phaseLoad),
        .loadVal (phaseLoadVal),
        .en      (phaseEn),
        .count   (phaseCount),
        .tc      (phaseTc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_idx <= 3'd0;
            isScatter <= 1'b0;
            isChase   <= 1'b0;
            reverse   <= 1'b0;
        end else begin
            reverse <= 1'b0;
            if (game_start) begin
                state     <= SCATTER;
                phase_idx <= 3'd0;
                isScatter <= 1'b1;
                isChase   <= 1'b0;
            end else if (active) begin
                if (pelletAccept) begin
                    isScatter <= 1'b0;
                    isChase   <= 1'b0;
                    reverse   <= ~frightened;
                end else if (frightExpire) begin
                    isScatter <= (state == SCATTER);
                    isChase   <= (state == CHASE);
                end else if (phaseExpire) begin
                    state     <= (state == SCATTER) ? CHASE : SCATTER;
                    phase_idx <= phase_idx + 3'd1;
                    isScatter <= (state == CHASE);
                    isChase   <= (state == SCATTER);
                    reverse   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ghost_mode_sched.sv
// Directed bench for ghost_mode_sched; frightened scenarios run only when
// GHOST_MODE_FRIGHT_EN is defined, otherwise power_pellet must be ignored.
module tb_ghost_mode_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_tick = 1'b0;
    logic game_start = 1'b0;
    logic pause = 1'b0;
    logic power_pellet = 1'b0;
    logic isScatter, isChase, isFrightened, fright_warn, reverse;
    logic [2:0] phase_idx;

    int checks = 0;
    int failures = 0;
    int revCount = 0;

    typedef struct {
        int         nTicks;
        logic [2:0] idx;
        logic       scat;
        logic       chase;
        int         rev;
    } vec_t;

    vec_t tbl[11];

    ghost_mode_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .game_start   (game_start),
        .pause        (pause),
        .power_pellet (power_pellet),
        .isScatter    (isScatter),
        .isChase      (isChase),
        .isFrightened (isFrightened),
        .fright_warn  (fright_warn),
        .reverse      (reverse),
        .phase_idx    (phase_idx)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic checkOuts(input string name, input logic s, input logic c,
                             input logic f, input logic w, input logic [2:0] idx);
        check({name, ".scatter"}, 32'(isScatter), 32'(s));
        check({name, ".chase"}, 32'(isChase), 32'(c));
        check({name, ".fright"}, 32'(isFrightened), 32'(f));
        check({name, ".warn"}, 32'(fright_warn), 32'(w));
        check({name, ".idx"}, 32'(phase_idx), 32'(idx));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (reverse) revCount++;
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic startGame();
        game_start = 1'b1;
        step();
        game_start = 1'b0;
    endtask

    task automatic pellet();
        power_pellet = 1'b1;
        step();
        power_pellet = 1'b0;
    endtask

    task automatic pelletTick();
        power_pellet = 1'b1;
        frame_tick = 1'b1;
        step();
        power_pellet = 1'b0;
        frame_tick = 1'b0;
    endtask

    initial begin
        // Cumulative ticks: 420, 1620, 2040, 3240, 3540, 4740, 5040, 5160, 15160.
        tbl[0]  = '{419,   3'd0, 1'b1, 1'b0, 0};
        tbl[1]  = '{1,     3'd1, 1'b0, 1'b1, 1};
        tbl[2]  = '{1199,  3'd1, 1'b0, 1'b1, 0};
        tbl[3]  = '{1,     3'd2, 1'b1, 1'b0, 1};
        tbl[4]  = '{420,   3'd3, 1'b0, 1'b1, 1};
        tbl[5]  = '{1200,  3'd4, 1'b1, 1'b0, 1};
        tbl[6]  = '{300,   3'd5, 1'b0, 1'b1, 1};
        tbl[7]  = '{1200,  3'd6, 1'b1, 1'b0, 1};
        tbl[8]  = '{300,   3'd7, 1'b0, 1'b1, 1};
        tbl[9]  = '{120,   3'd7, 1'b0, 1'b1, 0};
        tbl[10] = '{10000, 3'd7, 1'b0, 1'b1, 0};

        repeat (2) step();
        checkOuts("reset", 0, 0, 0, 0, 3'd0);
        check("reset.reverse", 32'(reverse), 0);
        rst_n = 1'b1;

        ticks(20);
        checkOuts("idle_ticks", 0, 0, 0, 0, 3'd0);

        revCount = 0;
        startGame();
        checkOuts("start", 1, 0, 0, 0, 3'd0);
        check("start.rev", 32'(revCount), 0);

        for (int i = 0; i < 11; i++) begin
            revCount = 0;
            ticks(tbl[i].nTicks);
            check($sformatf("sched%0d.idx", i), 32'(phase_idx), 32'(tbl[i].idx));
            check($sformatf("sched%0d.scatter", i), 32'(isScatter), 32'(tbl[i].scat));
            check($sformatf("sched%0d.chase", i), 32'(isChase), 32'(tbl[i].chase));
            check($sformatf("sched%0d.rev", i), 32'(revCount), 32'(tbl[i].rev));
        end

        // Pause mid-chase freezes the phase timer.
        startGame();
        ticks(420);
        ticks(100);
        revCount = 0;
        pause = 1'b1;
        ticks(500);
        checkOuts("paused", 0, 1, 0, 0, 3'd1);
        check("paused.rev", 32'(revCount), 0);
        pause = 1'b0;
        ticks(1099);
        checkOuts("unpause_hold", 0, 1, 0, 0, 3'd1);
        ticks(1);
        checkOuts("unpause_expire", 1, 0, 0, 0, 3'd2);

`ifdef GHOST_MODE_FRIGHT_EN
        // Pellet at phase-0 frame 100, warn window, resume with 320 frames left.
        startGame();
        ticks(100);
        revCount = 0;
        pellet();
        checkOuts("fright_on", 0, 0, 1, 0, 3'd0);
        check("fright_on.rev", 32'(revCount), 1);
        ticks(239);
        checkOuts("fright_239", 0, 0, 1, 0, 3'd0);
        ticks(1);
        checkOuts("fright_240", 0, 0, 1, 1, 3'd0);
        ticks(119);
        checkOuts("fright_359", 0, 0, 1, 1, 3'd0);
        revCount = 0;
        ticks(1);
        checkOuts("fright_end", 1, 0, 0, 0, 3'd0);
        check("fright_end.rev", 32'(revCount), 0);
        ticks(319);
        checkOuts("resume_319", 1, 0, 0, 0, 3'd0);
        ticks(1);
        checkOuts("resume_320", 0, 1, 0, 0, 3'd1);
        check("resume_320.rev", 32'(revCount), 1);

        // Second pellet at fright frame 300 reloads without reversing.
        startGame();
        ticks(10);
        pellet();
        ticks(300);
        checkOuts("refright_pre", 0, 0, 1, 1, 3'd0);
        revCount = 0;
        pellet();
        checkOuts("refright", 0, 0, 1, 0, 3'd0);
        check("refright.rev", 32'(revCount), 0);
        ticks(239);
        check("refright_239.warn", 32'(fright_warn), 0);
        ticks(1);
        check("refright_240.warn", 32'(fright_warn), 1);
        ticks(119);
        check("refright_359.fright", 32'(isFrightened), 1);
        ticks(1);
        checkOuts("refright_end", 1, 0, 0, 0, 3'd0);

        // Pellet coincident with phase expiry: phase held at its last frame.
        startGame();
        ticks(419);
        revCount = 0;
        pelletTick();
        checkOuts("coinc", 0, 0, 1, 0, 3'd0);
        check("coinc.rev", 32'(revCount), 1);
        ticks(360);
        checkOuts("coinc_resume", 1, 0, 0, 0, 3'd0);
        ticks(1);
        checkOuts("coinc_expire", 0, 1, 0, 0, 3'd1);

        // Pellet while paused is accepted; game_start mid-fright restarts cleanly.
        pause = 1'b1;
        pellet();
        check("pause_pellet.fright", 32'(isFrightened), 1);
        pause = 1'b0;
        revCount = 0;
        startGame();
        checkOuts("restart_fright", 1, 0, 0, 0, 3'd0);
        check("restart_fright.rev", 32'(revCount), 0);

        // Async reset mid-fright.
        ticks(5);
        pellet();
        ticks(250);
        check("pre_reset.warn", 32'(fright_warn), 1);
        rst_n = 1'b0;
        #5;
        checkOuts("async_reset", 0, 0, 0, 0, 3'd0);
        check("async_reset.reverse", 32'(reverse), 0);
`else
        // Without frightened support the pellet has no effect.
        startGame();
        ticks(100);
        revCount = 0;
        pellet();
        checkOuts("pellet_ignored", 1, 0, 0, 0, 3'd0);
        check("pellet_ignored.rev", 32'(revCount), 0);
        ticks(319);
        checkOuts("noext_319", 1, 0, 0, 0, 3'd0);
        ticks(1);
        checkOuts("noext_320", 0, 1, 0, 0, 3'd1);

        startGame();
        ticks(419);
        pelletTick();
        checkOuts("coinc_noext", 0, 1, 0, 0, 3'd1);

        // Async reset mid-phase.
        ticks(30);
        rst_n = 1'b0;
        #5;
        checkOuts("async_reset", 0, 0, 0, 0, 3'd0);
        check("async_reset.reverse", 32'(reverse), 0);
`endif

        step();
        rst_n = 1'b1;
        ticks(50);
        pellet();
        checkOuts("post_reset_idle", 0, 0, 0, 0, 3'd0);
        check("post_reset_idle.reverse", 32'(reverse), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
